// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM states and schedule helper functions.
package sha256_pkg;

    localparam int SHA256_ROUNDS    = 64;
    localparam int SHA256_BLK_WORDS = 16;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXPAND
    } state_e;

    function automatic logic [31:0] rotr32(
        input logic [31:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sigma0_256(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sigma1_256(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational SHA-256 schedule expansion from a 16-word window.
module sha256_w_expand
    import sha256_pkg::*;
(
    input  logic [31:0] w0_i,
    input  logic [31:0] w1_i,
    input  logic [31:0] w9_i,
    input  logic [31:0] w14_i,
    output logic [31:0] val_o
);

    assign val_o = sigma1_256(w14_i) + w9_i + sigma0_256(w1_i) + w0_i;

endmodule

// File: rtl/sha256_sched_seq.sv
// SHA-256 message schedule sequencer: loads 16 words per block, expands
// to 64, and streams them through a registered valid/ready output.
module sha256_sched_seq
    import sha256_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NBLK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [NBLK_W-1:0] nblocks,
    output logic              done,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_wlast,
    output logic              out_blast
);

    state_e            state_q, state_d;
    logic [5:0]        t_q, t_d;
    logic [NBLK_W-1:0] blk_q, blk_d;
    logic [DATA_W-1:0] w_q [SHA256_BLK_WORDS];

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [5:0]        out_idx_q;
    logic              out_wlast_q;
    logic              out_blast_q;

    logic              adv;
    logic              issue;
    logic [DATA_W-1:0] val;
    logic [DATA_W-1:0] word;

    sha256_w_expand u_expand (
        .w0_i  (w_q[0]),
        .w1_i  (w_q[1]),
        .w9_i  (w_q[9]),
        .w14_i (w_q[14]),
        .val_o (val)
    );

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = (state_q == LOAD) && adv;
    assign issue    = adv && ((state_q == LOAD && in_valid) || state_q == EXPAND);
    assign word     = (state_q == LOAD) ? in_data : val;
    assign done     = (state_q == IDLE);

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        blk_d   = blk_q;
        if (issue) t_d = t_q + 6'd1;
        unique case (state_q)
            IDLE: begin
                if (run && nblocks != '0) begin
                    state_d = LOAD;
                    t_d     = '0;
                    blk_d   = nblocks;
                end
            end
            LOAD: begin
                if (issue && t_q == 6'(SHA256_BLK_WORDS - 1)) state_d = EXPAND;
            end
            EXPAND: begin
                if (issue && t_q == 6'(SHA256_ROUNDS - 1)) begin
                    blk_d   = blk_q - 1'b1;
                    state_d = (blk_q > NBLK_W'(1)) ? LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            t_q         <= '0;
            blk_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_wlast_q <= 1'b0;
            out_blast_q <= 1'b0;
            for (int i = 0; i < SHA256_BLK_WORDS; i++) w_q[i] <= '0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            blk_q   <= blk_d;
            if (issue) begin
                out_valid_q <= 1'b1;
                out_data_q  <= word;
                out_idx_q   <= t_q;
                out_wlast_q <= (t_q == 6'd63);
                out_blast_q <= (t_q == 6'd63) && (blk_q == NBLK_W'(1));
                for (int i = 0; i < SHA256_BLK_WORDS - 1; i++) w_q[i] <= w_q[i+1];
                w_q[SHA256_BLK_WORDS-1] <= word;
            end else if (adv) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_wlast = out_wlast_q;
    assign out_blast = out_blast_q;

endmodule

// File: tb/tb_sha256_sched_seq.sv
// Randomized self-checking bench for the SHA-256 schedule sequencer.
module tb_sha256_sched_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic [15:0] nblocks = '0;
    logic        done;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [5:0]  out_idx;
    logic        out_wlast;
    logic        out_blast;

    int total = 0;
    int bad = 0;

    logic [31:0] msg   [0:127];
    logic [31:0] exp_w [0:255];
    logic [31:0] got   [0:255];
    int          ocyc  [0:255];
    int          icyc  [0:127];

    always #5 clk = ~clk;

    sha256_sched_seq dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .nblocks   (nblocks),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_wlast (out_wlast),
        .out_blast (out_blast)
    );

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook recurrence over the full 64-entry W array of each block.
    task automatic model(input int nblk);
        logic [31:0] w [64];
        logic [31:0] s0, s1;
        for (int b = 0; b < nblk; b++) begin
            for (int t = 0; t < 16; t++) w[t] = msg[16*b+t];
            for (int t = 16; t < 64; t++) begin
                s0 = rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = s1 + w[t-7] + s0 + w[t-16];
            end
            for (int t = 0; t < 64; t++) exp_w[64*b+t] = w[t];
        end
    endtask

    task automatic set_abc(input int b);
        for (int i = 0; i < 16; i++) msg[16*b+i] = 32'h0;
        msg[16*b]    = 32'h61626380;
        msg[16*b+15] = 32'h00000018;
    endtask

    task automatic set_rand(input int b);
        for (int i = 0; i < 16; i++) msg[16*b+i] = $urandom;
    endtask

    task automatic stream(input int nblk, input int rdy_pct, input int gap,
                          input bit ign_run, input int rst_idx);
        int ai, ao, cyc;
        bit held, stop, ir_bad;
        logic [31:0] hd;
        logic [5:0]  hi;
        logic [5:0]  ei;
        bit ewl, ebl;
        ai = 0; ao = 0; cyc = 0;
        held = 0; stop = 0; ir_bad = 0;
        hd = '0; hi = '0;
        model(nblk);
        @(negedge clk);
        run = 1'b1; nblocks = 16'(nblk); in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        run = 1'b0;
        #1;
        total++;
        if (done !== 1'b0) $display("FAIL start_done: got %b exp 0", done);
        while (!stop && ao < 64*nblk && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(99) < rdy_pct);
            in_valid  = (ai < 16*nblk) && (gap <= 1 || cyc % gap == 0);
            in_data   = in_valid ? msg[ai] : $urandom;
            run       = ign_run && ao == 20;
            nblocks   = 16'd7;
            #1;
            if (held) begin
                total++;
                if (!(out_valid === 1'b1 && out_data === hd && out_idx === hi))
                    $display("FAIL hold: got v=%b d=%h i=%0d exp v=1 d=%h i=%0d",
                             out_valid, out_data, out_idx, hd, hi);
            end
            held = 0;
            if (in_ready === 1'b1 && ai > 0 && ai % 16 == 0 && ao + 1 < 64*(ai/16))
                ir_bad = 1;
            if (out_valid === 1'b1) begin
                if (rst_idx >= 0 && out_idx == 6'(rst_idx)) begin
                    rst = 1'b1;
                    stop = 1;
                end else if (out_ready) begin
                    ei  = 6'(ao % 64);
                    ewl = (ao % 64 == 63);
                    ebl = (ao == 64*nblk - 1);
                    total++;
                    if (out_data !== exp_w[ao] || out_idx !== ei || out_wlast !== ewl
                        || out_blast !== ebl || done !== ebl) begin
                        bad++;
                        $display("FAIL word%0d: got d=%h i=%0d wl=%b bl=%b dn=%b exp d=%h i=%0d wl=%b bl=%b dn=%b",
                                 ao, out_data, out_idx, out_wlast, out_blast, done,
                                 exp_w[ao], ei, ewl, ebl, ebl);
                    end
                    got[ao]  = out_data;
                    ocyc[ao] = cyc;
                    ao++;
                end else begin
                    held = 1;
                    hd = out_data;
                    hi = out_idx;
                end
            end
            if (in_valid && in_ready === 1'b1) begin
                icyc[ai] = cyc;
                ai++;
            end
        end
        run = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (stop) begin
            @(negedge clk);
            rst = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b0 || done !== 1'b1) begin
                bad++;
                $display("FAIL rst_abort: got v=%b done=%b exp v=0 done=1", out_valid, done);
            end
        end else begin
            total++;
            if (ao != 64*nblk) begin
                bad++;
                $display("FAIL count: got %0d words exp %0d", ao, 64*nblk);
            end
            total++;
            if (ir_bad) begin
                bad++;
                $display("FAIL in_ready_expand: got 1 exp 0");
            end
            repeat (3) @(negedge clk);
            #1;
            total++;
            if (done !== 1'b1 || out_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle_after: got done=%b v=%b exp done=1 v=0", done, out_valid);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ctl: got done=%b v=%b ir=%b exp 1 0 0", done, out_valid, in_ready);
        end
        total++;
        if (out_data !== 32'h0 || out_idx !== 6'd0 || out_wlast !== 1'b0 || out_blast !== 1'b0) begin
            bad++;
            $display("FAIL reset_out: got d=%h i=%0d wl=%b bl=%b exp 0", out_data, out_idx, out_wlast, out_blast);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_abc;
        set_abc(0);
        stream(1, 100, 1, 0, -1);
        total++;
        if (got[16] !== 32'h61626380) begin
            bad++;
            $display("FAIL abc_w16: got %h exp 61626380", got[16]);
        end
        total++;
        if (got[17] !== 32'h000F0000) begin
            bad++;
            $display("FAIL abc_w17: got %h exp 000f0000", got[17]);
        end
    endtask

    task automatic test_stall;
        set_abc(0);
        stream(1, 50, 1, 0, -1);
    endtask

    task automatic test_back_to_back;
        set_abc(0);
        set_rand(1);
        stream(2, 100, 1, 0, -1);
        total++;
        if (ocyc[64] != ocyc[63] + 1) begin
            bad++;
            $display("FAIL no_bubble: got cyc %0d exp %0d", ocyc[64], ocyc[63] + 1);
        end
    endtask

    task automatic test_gap;
        set_rand(0);
        stream(1, 100, 3, 0, -1);
        for (int k = 0; k < 16; k++) begin
            total++;
            if (ocyc[k] != icyc[k] + 1) begin
                bad++;
                $display("FAIL gap_lat%0d: got cyc %0d exp %0d", k, ocyc[k], icyc[k] + 1);
            end
        end
        total++;
        if (ocyc[16] != icyc[15] + 2) begin
            bad++;
            $display("FAIL expand_start: got cyc %0d exp %0d", ocyc[16], icyc[15] + 2);
        end
    endtask

    task automatic test_zero_and_ignore;
        @(negedge clk);
        run = 1'b1; nblocks = 16'd0; in_valid = 1'b1; in_data = 32'h12345678;
        @(negedge clk);
        run = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            total++;
            if (done !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL zero_blk%0d: got done=%b ir=%b exp 1 0", k, done, in_ready);
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        set_rand(0);
        stream(1, 70, 1, 1, -1);
    endtask

    task automatic test_mid_reset;
        set_abc(0);
        stream(1, 100, 1, 0, 30);
        set_abc(0);
        stream(1, 100, 1, 0, -1);
        total++;
        if (got[17] !== 32'h000F0000) begin
            bad++;
            $display("FAIL rerun_w17: got %h exp 000f0000", got[17]);
        end
    endtask

    initial begin
        test_reset;
        test_abc;
        test_stall;
        test_back_to_back;
        test_gap;
        test_zero_and_ignore;
        test_mid_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
